// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU decode unit: ALU control codes,
// alu_op classes, funct7 patterns and the handshake FSM state type.
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLTU = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_ARITH  = 2'b10;
    localparam logic [1:0] ALU_OP_RSVD   = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_VALID = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_lookup.sv
// Combinational decode of alu_op/funct3/funct7/op5 into ALU control, M-op and
// illegal flags. RV32M decode is enabled by defining ALU_DECODE_MULDIV_EN.
module alu_op_lookup
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5
) (
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              op5,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_muldiv,
    output logic              illegal
);

    logic isBase;
    logic isAlt;
    logic isMd;
    logic [4:0] code;
    logic muldiv;
    logic bad;

    assign isBase = (funct7 == FUNCT7_BASE);
    assign isAlt  = (funct7 == FUNCT7_ALT);
`ifdef ALU_DECODE_MULDIV_EN
    assign isMd   = op5 && (funct7 == FUNCT7_MULDIV);
`else
    assign isMd   = 1'b0;
`endif

    // I-type funct7 is immediate data, so only shift-immediates constrain it.
    always_comb begin
        code   = ALU_ADD;
        muldiv = 1'b0;
        bad    = 1'b0;
        case (alu_op)
            ALU_OP_MEM:    code = ALU_ADD;
            ALU_OP_BRANCH: code = ALU_SUB;
            ALU_OP_ARITH: begin
                if (isMd) begin
                    code   = {2'b10, funct3};
                    muldiv = 1'b1;
                end else begin
                    if (op5 && !isBase && !isAlt)
                        bad = 1'b1;
                    if (op5 && isAlt && funct3 != 3'b000 && funct3 != 3'b101)
                        bad = 1'b1;
                    case (funct3)
                        3'b000: code = (op5 && isAlt) ? ALU_SUB : ALU_ADD;
                        3'b001: begin
                            code = ALU_SLL;
                            if (!isBase)
                                bad = 1'b1;
                        end
                        3'b010: code = ALU_SLT;
                        3'b011: code = ALU_SLTU;
                        3'b100: code = ALU_XOR;
                        3'b101: begin
                            if (isAlt)
                                code = ALU_SRA;
                            else if (isBase)
                                code = ALU_SRL;
                            else
                                bad = 1'b1;
                        end
                        3'b110: code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            code   = ALU_ADD;
            muldiv = 1'b0;
        end
    end

    assign ctrl      = CTRL_W'(code);
    assign is_muldiv = muldiv;
    assign illegal   = bad;

endmodule

// File: rtl/alu_decode_unit.sv
// Registered, valid/ready ALU decode stage with multi-cycle mul/div occupancy.
// Define ALU_DECODE_MULDIV_EN to decode RV32M and enable the latency counter.
module alu_decode_unit
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              op5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              is_muldiv,
    output logic              illegal
);

    if (CTRL_W < 5 || MULDIV_LAT < 1) begin : gBadParams
        $error("alu_decode_unit: CTRL_W must be >= 5 and MULDIV_LAT >= 1");
    end

    logic [CTRL_W-1:0] lkCtrl;
    logic              lkMuldiv;
    logic              lkIllegal;

    alu_op_lookup #(.CTRL_W(CTRL_W)) uLookup (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .op5       (op5),
        .ctrl      (lkCtrl),
        .is_muldiv (lkMuldiv),
        .illegal   (lkIllegal)
    );

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              muldiv_q, muldiv_d;
    logic              illegal_q, illegal_d;
    logic              accept;

`ifdef ALU_DECODE_MULDIV_EN
    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == ST_VALID);
    assign alu_control = ctrl_q;
    assign is_muldiv   = muldiv_q;
    assign illegal     = illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            muldiv_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            muldiv_q  <= muldiv_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_DECODE_MULDIV_EN
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`endif

    // Acceptance overrides the drain-to-IDLE path so VALID can chain without a bubble.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        muldiv_d  = muldiv_q;
        illegal_d = illegal_q;
`ifdef ALU_DECODE_MULDIV_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
`ifdef ALU_DECODE_MULDIV_EN
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1))
                    state_d = ST_VALID;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_VALID: begin
                if (out_ready && !in_valid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            ctrl_d    = lkCtrl;
            muldiv_d  = lkMuldiv;
            illegal_d = lkIllegal;
            state_d   = ST_VALID;
`ifdef ALU_DECODE_MULDIV_EN
            if (lkMuldiv) begin
                cnt_d = CNT_W'(MULDIV_LAT - 1);
                if (MULDIV_LAT > 1)
                    state_d = ST_BUSY;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed bench for alu_decode_unit; expectations follow ALU_DECODE_MULDIV_EN.
module tb_alu_decode_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       op5;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] alu_control;
    logic       is_muldiv;
    logic       illegal;

    int nCompared   = 0;
    int nMismatched = 0;

    alu_decode_unit #(.CTRL_W(5), .MULDIV_LAT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (op5),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .is_muldiv   (is_muldiv),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic o5);
        alu_op   = op;
        funct3   = f3;
        funct7   = f7;
        op5      = o5;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        nCompared++;
        if (alu_control !== 5'd0 || is_muldiv !== 1'b0 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got ctrl=%b md=%b ill=%b expected 00000/0/0",
                     alu_control, is_muldiv, illegal);
        end
        // R-type sub immediately after reset, latency 1
        applyStimulus(2'b10, 3'b000, 7'b0100000, 1'b1);
        step();
        in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || alu_control !== 5'b00001 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL first_sub: got v=%b ctrl=%b ill=%b expected 1/00001/0",
                     out_valid, alu_control, illegal);
        end
        step();
        nCompared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL drain_idle: got v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       o5;
        logic [4:0] ctrl;
        logic       ill;
    } vec_t;

    task automatic test_decode();
        vec_t vecs[13];
        vecs[0]  = '{2'b10, 3'b000, 7'b0100000, 1'b0, 5'b00000, 1'b0};
        vecs[1]  = '{2'b10, 3'b101, 7'b0100000, 1'b1, 5'b01001, 1'b0};
        vecs[2]  = '{2'b10, 3'b000, 7'b0010000, 1'b1, 5'b00000, 1'b1};
        vecs[3]  = '{2'b10, 3'b001, 7'b0100000, 1'b0, 5'b00000, 1'b1};
        vecs[4]  = '{2'b10, 3'b111, 7'b0100000, 1'b1, 5'b00000, 1'b1};
        vecs[5]  = '{2'b11, 3'b000, 7'b0000000, 1'b0, 5'b00000, 1'b1};
        vecs[6]  = '{2'b01, 3'b010, 7'b0000000, 1'b1, 5'b00001, 1'b0};
        vecs[7]  = '{2'b10, 3'b111, 7'b0000000, 1'b1, 5'b00010, 1'b0};
        vecs[8]  = '{2'b10, 3'b011, 7'b0101010, 1'b0, 5'b00110, 1'b0};
        vecs[9]  = '{2'b10, 3'b101, 7'b0000000, 1'b0, 5'b01000, 1'b0};
        vecs[10] = '{2'b10, 3'b110, 7'b0000000, 1'b1, 5'b00011, 1'b0};
        vecs[11] = '{2'b10, 3'b010, 7'b0000000, 1'b1, 5'b00101, 1'b0};
        vecs[12] = '{2'b10, 3'b101, 7'b0000001, 1'b0, 5'b00000, 1'b1};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].o5);
            step();
            in_valid = 1'b0;
            nCompared++;
            if (out_valid !== 1'b1 || alu_control !== vecs[i].ctrl ||
                illegal !== vecs[i].ill || is_muldiv !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL decode_%0d: got v=%b ctrl=%b ill=%b md=%b expected 1/%b/%b/0",
                         i, out_valid, alu_control, illegal, is_muldiv, vecs[i].ctrl, vecs[i].ill);
            end
            step();
        end
    endtask

    task automatic test_muldiv();
        applyStimulus(2'b10, 3'b100, 7'b0000001, 1'b1);
        step();
        in_valid = 1'b0;
`ifdef ALU_DECODE_MULDIV_EN
        for (int i = 0; i < 3; i++) begin
            nCompared++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL muldiv_busy_%0d: got rdy=%b v=%b expected 0/0",
                         i, in_ready, out_valid);
            end
            step();
        end
        nCompared++;
        if (out_valid !== 1'b1 || alu_control !== 5'b10100 || is_muldiv !== 1'b1 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL muldiv_result: got v=%b ctrl=%b md=%b ill=%b expected 1/10100/1/0",
                     out_valid, alu_control, is_muldiv, illegal);
        end
`else
        nCompared++;
        if (out_valid !== 1'b1 || alu_control !== 5'b00000 || is_muldiv !== 1'b0 || illegal !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL muldiv_disabled: got v=%b ctrl=%b md=%b ill=%b expected 1/00000/0/1",
                     out_valid, alu_control, is_muldiv, illegal);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        applyStimulus(2'b10, 3'b100, 7'b0000000, 1'b1);
        out_ready = 1'b0;
        step();
        // A competing request during the stall must be ignored
        applyStimulus(2'b10, 3'b110, 7'b0000000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            nCompared++;
            if (out_valid !== 1'b1 || alu_control !== 5'b00100 || illegal !== 1'b0 || in_ready !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL hold_%0d: got v=%b ctrl=%b ill=%b rdy=%b expected 1/00100/0/0",
                         i, out_valid, alu_control, illegal, in_ready);
            end
            step();
        end
        applyStimulus(2'b10, 3'b001, 7'b0000000, 1'b1);
        out_ready = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL release_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || alu_control !== 5'b00111) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back: got v=%b ctrl=%b expected 1/00111", out_valid, alu_control);
        end
        step();
    endtask

    task automatic test_reset_busy();
`ifdef ALU_DECODE_MULDIV_EN
        applyStimulus(2'b10, 3'b000, 7'b0000001, 1'b1);
        step();
        in_valid = 1'b0;
        step();
`else
        applyStimulus(2'b10, 3'b100, 7'b0000000, 1'b1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        nCompared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_control !== 5'd0 ||
            is_muldiv !== 1'b0 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: got v=%b rdy=%b ctrl=%b md=%b ill=%b expected 0/1/00000/0/0",
                     out_valid, in_ready, alu_control, is_muldiv, illegal);
        end
        applyStimulus(2'b00, 3'b010, 7'b0000000, 1'b0);
        step();
        in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || alu_control !== 5'd0 || is_muldiv !== 1'b0 || illegal !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_add: got v=%b ctrl=%b md=%b ill=%b expected 1/00000/0/0",
                     out_valid, alu_control, is_muldiv, illegal);
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7    = 7'b0000000;
        op5       = 1'b0;
        test_reset();
        test_decode();
        test_muldiv();
        test_back_to_back();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
